// File: rtl/pc_fetch_if.sv
// pc_fetch_if: bundle between the fetch unit and its surroundings.
//   slave  : seen by pc_fetch_unit (redirect/hazard/interrupt inputs, memory
//            read data in; PC, vector select, IF/ID register and interrupt
//            handshake out).
//   master : the opposite view, used by whatever drives the fetch unit.
interface pc_fetch_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic [AW-1:0] pc_in;
   logic          pc_load;
   logic          stall;
   logic          flush;
   logic          intr;
   logic [DW-1:0] instr_in;
   logic [AW-1:0] vec_data;

   logic [AW-1:0] pc;
   logic          vec_addr;
   logic [DW-1:0] if_id_instr;
   logic [AW-1:0] if_id_pc1;
   logic          if_id_valid;
   logic          int_ack;
   logic [AW-1:0] ret_pc;

   modport master (
      output pc_in, pc_load, stall, flush, intr, instr_in, vec_data,
      input  pc, vec_addr, if_id_instr, if_id_pc1, if_id_valid, int_ack, ret_pc
   );

   modport slave (
      input  pc_in, pc_load, stall, flush, intr, instr_in, vec_data,
      output pc, vec_addr, if_id_instr, if_id_pc1, if_id_valid, int_ack, ret_pc
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, reset/interrupt vector loading and the
// IF/ID pipeline register of the fetch stage.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - pc_fetch_if.slave: pc_in/pc_load redirect, stall, flush, intr,
//          instr_in (memory data at pc), vec_data (memory data at vec_addr);
//          outputs pc, vec_addr, if_id_instr/pc1/valid, int_ack, ret_pc.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_RSTV | load pc from M[0] (reset vector); intr requests are dropped
// S_RUN  | normal fetch: redirect > interrupt take > stall > increment
// S_INTV | load pc from M[1] (interrupt vector), vec_addr = 1
module pc_fetch_unit #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input logic        clk,
   input logic        rst,
   pc_fetch_if.slave  bus
);

   typedef enum logic [1:0] {S_RSTV, S_RUN, S_INTV} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [DW-1:0] instr_q, instr_d;
   logic [AW-1:0] pc1_q, pc1_d;
   logic          valid_q, valid_d;
   logic          ack_q, ack_d;
   logic [AW-1:0] ret_q, ret_d;
   logic          pend_q, pend_d;
   logic [AW-1:0] pc_inc;

   // Natural AW-bit wrap: all-ones rolls over to zero.
   assign pc_inc = pc_q + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_RSTV;
         pc_q    <= '0;
         instr_q <= '0;
         pc1_q   <= '0;
         valid_q <= 1'b0;
         ack_q   <= 1'b0;
         ret_q   <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc1_q   <= pc1_d;
         valid_q <= valid_d;
         ack_q   <= ack_d;
         ret_q   <= ret_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pc1_d   = pc1_q;
      valid_d = valid_q;
      ack_d   = 1'b0;
      ret_d   = ret_q;
      pend_d  = pend_q;
      case (state_q)
         S_RSTV: begin
            pc_d    = bus.vec_data;
            valid_d = 1'b0;
            state_d = S_RUN;
         end
         S_RUN: begin
            pend_d = pend_q | bus.intr;
            if (bus.pc_load) begin
               // Redirect wins even over a stall; a same-cycle intr stays pending.
               pc_d    = bus.pc_in;
               valid_d = 1'b0;
            end else if ((pend_q || bus.intr) && !bus.stall) begin
               // pc is not advanced: it is the return address.
               ret_d   = pc_q;
               valid_d = 1'b0;
               ack_d   = 1'b1;
               state_d = S_INTV;
            end else if (bus.stall) begin
               if (bus.flush) valid_d = 1'b0;
            end else begin
               pc_d    = pc_inc;
               instr_d = bus.instr_in;
               pc1_d   = pc_inc;
               valid_d = ~bus.flush;
            end
         end
         S_INTV: begin
            pc_d    = bus.vec_data;
            // A new request in the vector cycle survives the clear.
            pend_d  = bus.intr;
            valid_d = 1'b0;
            state_d = S_RUN;
         end
         default: state_d = S_RSTV;
      endcase
   end

   assign bus.pc          = pc_q;
   assign bus.vec_addr    = (state_q == S_INTV);
   assign bus.if_id_instr = instr_q;
   assign bus.if_id_pc1   = pc1_q;
   assign bus.if_id_valid = valid_q;
   assign bus.int_ack     = ack_q;
   assign bus.ret_pc      = ret_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
   localparam int AW = 8;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pc_fetch_if #(.AW(AW), .DW(DW)) bus ();

   pc_fetch_unit #(.AW(AW), .DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic [DW-1:0] imem [256];
   logic [AW-1:0] m0, m1;

   assign bus.instr_in = imem[bus.pc];
   assign bus.vec_data = bus.vec_addr ? m1 : m0;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic ld, input logic [7:0] pin, input logic st,
                        input logic fl, input logic ir);
      bus.pc_load = ld;
      bus.pc_in   = pin;
      bus.stall   = st;
      bus.flush   = fl;
      bus.intr    = ir;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       ld;
      logic [7:0] pin;
      logic       st, fl, ir;
      logic [7:0] e_pc;
      logic       e_val;
      logic [7:0] e_pc1;
      logic       e_ack, e_vec;
      logic [7:0] e_ret;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic ld, input logic [7:0] pin, input logic st, input logic fl,
                      input logic ir, input logic [7:0] e_pc, input logic e_val,
                      input logic [7:0] e_pc1, input logic e_ack, input logic e_vec,
                      input logic [7:0] e_ret);
      vec_t v;
      v.ld = ld; v.pin = pin; v.st = st; v.fl = fl; v.ir = ir;
      v.e_pc = e_pc; v.e_val = e_val; v.e_pc1 = e_pc1;
      v.e_ack = e_ack; v.e_vec = e_vec; v.e_ret = e_ret;
      tbl.push_back(v);
   endtask

   // Reference model: the fetch stage as described by its rules, one step per edge.
   localparam int M_RSTV = 0, M_RUN = 1, M_INTV = 2;
   int       m_mode;
   int       m_pc, m_instr, m_pc1, m_ret;
   bit       m_valid, m_ack, m_pend;

   task automatic model_reset();
      m_mode = M_RSTV; m_pc = 0; m_instr = 0; m_pc1 = 0; m_ret = 0;
      m_valid = 0; m_ack = 0; m_pend = 0;
   endtask

   task automatic model_step(input bit ld, input int pin, input bit st, input bit fl, input bit ir);
      m_ack = 0;
      if (m_mode == M_RSTV) begin
         m_pc = m0; m_valid = 0; m_mode = M_RUN;
      end else if (m_mode == M_INTV) begin
         m_pc = m1; m_valid = 0; m_pend = ir; m_mode = M_RUN;
      end else begin
         bit want_int = m_pend || ir;
         m_pend = want_int;
         if (ld) begin
            m_pc = pin; m_valid = 0;
         end else if (want_int && !st) begin
            m_ret = m_pc; m_valid = 0; m_ack = 1; m_mode = M_INTV;
         end else if (st) begin
            if (fl) m_valid = 0;
         end else begin
            m_instr = imem[m_pc];
            m_pc    = (m_pc + 1) % 256;
            m_pc1   = m_pc;
            m_valid = !fl;
         end
      end
   endtask

   initial begin
      drive(0, 8'h00, 0, 0, 0);
      for (int i = 0; i < 256; i++) imem[i] = 8'(i ^ 8'hA5);
      m0 = 8'h20;
      m1 = 8'h10;

      // ---------------- reset values ----------------
      tick();
      tick();
      check("rst pc", bus.pc, 0);
      check("rst valid", bus.if_id_valid, 0);
      check("rst pc1", bus.if_id_pc1, 0);
      check("rst instr", bus.if_id_instr, 0);
      check("rst ack", bus.int_ack, 0);
      check("rst ret", bus.ret_pc, 0);
      check("rst vec_addr", bus.vec_addr, 0);
      rst = 1'b0;

      // ---------------- directed table ----------------
      //   ld pin   st fl ir   pc   val pc1  ack vec ret
      add(0, 8'h00, 0, 0, 0, 8'h20, 0, 8'h00, 0, 0, 8'h00);
      add(0, 8'h00, 0, 0, 0, 8'h21, 1, 8'h21, 0, 0, 8'h00);
      add(0, 8'h00, 0, 0, 0, 8'h22, 1, 8'h22, 0, 0, 8'h00);
      add(1, 8'h2F, 0, 0, 0, 8'h2F, 0, 8'h22, 0, 0, 8'h00);
      add(0, 8'h00, 0, 0, 0, 8'h30, 1, 8'h30, 0, 0, 8'h00);
      add(0, 8'h00, 1, 1, 0, 8'h30, 0, 8'h30, 0, 0, 8'h00);
      add(0, 8'h00, 1, 0, 0, 8'h30, 0, 8'h30, 0, 0, 8'h00);
      add(0, 8'h00, 0, 0, 0, 8'h31, 1, 8'h31, 0, 0, 8'h00);
      add(1, 8'h80, 1, 0, 0, 8'h80, 0, 8'h31, 0, 0, 8'h00);
      add(0, 8'h00, 0, 0, 0, 8'h81, 1, 8'h81, 0, 0, 8'h00);
      add(0, 8'h00, 0, 1, 0, 8'h82, 0, 8'h82, 0, 0, 8'h00);
      add(1, 8'hFE, 0, 0, 0, 8'hFE, 0, 8'h82, 0, 0, 8'h00);
      add(0, 8'h00, 0, 0, 0, 8'hFF, 1, 8'hFF, 0, 0, 8'h00);
      add(0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);
      add(1, 8'h50, 0, 0, 0, 8'h50, 0, 8'h00, 0, 0, 8'h00);
      add(0, 8'h00, 1, 0, 1, 8'h50, 0, 8'h00, 0, 0, 8'h00);
      add(0, 8'h00, 0, 0, 0, 8'h50, 0, 8'h00, 1, 1, 8'h50);
      add(0, 8'h00, 0, 0, 0, 8'h10, 0, 8'h00, 0, 0, 8'h50);
      add(0, 8'h00, 0, 0, 0, 8'h11, 1, 8'h11, 0, 0, 8'h50);
      add(1, 8'h60, 0, 0, 1, 8'h60, 0, 8'h11, 0, 0, 8'h50);
      add(0, 8'h00, 0, 0, 0, 8'h60, 0, 8'h11, 1, 1, 8'h60);
      add(0, 8'h00, 0, 0, 1, 8'h10, 0, 8'h11, 0, 0, 8'h60);
      add(0, 8'h00, 0, 0, 0, 8'h10, 0, 8'h11, 1, 1, 8'h10);
      add(0, 8'h00, 0, 0, 0, 8'h10, 0, 8'h11, 0, 0, 8'h10);
      add(0, 8'h00, 0, 0, 0, 8'h11, 1, 8'h11, 0, 0, 8'h10);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].ld, tbl[i].pin, tbl[i].st, tbl[i].fl, tbl[i].ir);
         tick();
         check($sformatf("tbl[%0d] pc", i), bus.pc, tbl[i].e_pc);
         check($sformatf("tbl[%0d] valid", i), bus.if_id_valid, tbl[i].e_val);
         check($sformatf("tbl[%0d] pc1", i), bus.if_id_pc1, tbl[i].e_pc1);
         check($sformatf("tbl[%0d] ack", i), bus.int_ack, tbl[i].e_ack);
         check($sformatf("tbl[%0d] vec_addr", i), bus.vec_addr, tbl[i].e_vec);
         check($sformatf("tbl[%0d] ret", i), bus.ret_pc, tbl[i].e_ret);
      end
      check("tbl instr@0x10", bus.if_id_instr, 8'h10 ^ 8'hA5);

      // ---------------- reset in the middle of the interrupt vector cycle ----------------
      drive(0, 8'h00, 0, 0, 1);
      tick();
      check("mid take ack", bus.int_ack, 1);
      check("mid take vec", bus.vec_addr, 1);
      check("mid take ret", bus.ret_pc, 8'h11);
      drive(0, 8'h00, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      check("async pc", bus.pc, 0);
      check("async vec", bus.vec_addr, 0);
      check("async ack", bus.int_ack, 0);
      check("async ret", bus.ret_pc, 0);
      check("async valid", bus.if_id_valid, 0);
      check("async pc1", bus.if_id_pc1, 0);
      check("async instr", bus.if_id_instr, 0);
      drive(0, 8'h00, 0, 0, 1);
      tick();
      m0 = 8'h44;
      rst = 1'b0;
      // intr during the reset-vector cycle must be dropped
      tick();
      check("rv pc", bus.pc, 8'h44);
      check("rv vec", bus.vec_addr, 0);
      check("rv ack", bus.int_ack, 0);
      check("rv valid", bus.if_id_valid, 0);
      drive(0, 8'h00, 0, 0, 0);
      tick();
      check("rv+1 pc", bus.pc, 8'h45);
      check("rv+1 ack", bus.int_ack, 0);
      check("rv+1 valid", bus.if_id_valid, 1);
      check("rv+1 pc1", bus.if_id_pc1, 8'h45);
      check("rv+1 instr", bus.if_id_instr, 8'h44 ^ 8'hA5);
      tick();
      check("rv+2 ack", bus.int_ack, 0);
      check("rv+2 pc", bus.pc, 8'h46);

      // ---------------- randomized run against the model ----------------
      rst = 1'b1;
      m0 = 8'($urandom);
      m1 = 8'($urandom);
      for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);
      model_reset();
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         bit ld, st, fl, ir;
         int pin;
         ld  = ($urandom_range(0, 7) == 0);
         st  = ($urandom_range(0, 3) == 0);
         fl  = ($urandom_range(0, 5) == 0);
         ir  = ($urandom_range(0, 11) == 0);
         pin = int'($urandom_range(0, 255));
         drive(ld, 8'(pin), st, fl, ir);
         model_step(ld, pin, st, fl, ir);
         tick();
         check($sformatf("rnd[%0d] pc", c), bus.pc, m_pc);
         check($sformatf("rnd[%0d] vec", c), bus.vec_addr, (m_mode == M_INTV) ? 1 : 0);
         check($sformatf("rnd[%0d] instr", c), bus.if_id_instr, m_instr);
         check($sformatf("rnd[%0d] pc1", c), bus.if_id_pc1, m_pc1);
         check($sformatf("rnd[%0d] valid", c), bus.if_id_valid, m_valid);
         check($sformatf("rnd[%0d] ack", c), bus.int_ack, m_ack);
         check($sformatf("rnd[%0d] ret", c), bus.ret_pc, m_ret);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
